// File: rtl/countdown_timer_if.sv
// Board-side signal bundle for the countdown timer: load/run controls in,
// four seven-segment digits and status flags out.
interface countdown_timer_if;
  logic       load;
  logic       start_stop;
  logic [6:0] load_sec;
  logic [6:0] HEX3;
  logic [6:0] HEX2;
  logic [6:0] HEX1;
  logic [6:0] HEX0;
  logic       running;
  logic       expired;

  modport master (
    output load, start_stop, load_sec,
    input  HEX3, HEX2, HEX1, HEX0, running, expired
  );

  modport slave (
    input  load, start_stop, load_sec,
    output HEX3, HEX2, HEX1, HEX0, running, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// SS.cc countdown timer: loads seconds from switches, counts down in
// centiseconds, flags expiry at 00.00 and drives four seven-segment digits.
module countdown_timer #(
  parameter int TICK_DIV = 500000,
  parameter int MAX_SEC  = 99
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [6:0]      sec_q;
  logic [6:0]      cs_q;
  logic [PW-1:0]   presc_q;
  logic            ss_p0;
  logic            ss_p1;
  logic            ss_p2;
  logic            go;
  logic            tick;
  logic [6:0]      dec_sec;
  logic [6:0]      dec_cs;
  logic            dec_zero;
  logic [6:0]      hex3_p0;
  logic [6:0]      hex2_p0;
  logic [6:0]      hex1_p0;
  logic [6:0]      hex0_p0;

  function automatic logic [6:0] sat_sec(input logic [6:0] v);
    return (v > 7'(MAX_SEC)) ? 7'(MAX_SEC) : v;
  endfunction

  function automatic logic [3:0] tens_of(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Stage p0..p2: start_stop synchronizer and rising-edge detect
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ss_p0 <= 1'b0;
      ss_p1 <= 1'b0;
      ss_p2 <= 1'b0;
    end else begin
      ss_p0 <= bus.start_stop;
      ss_p1 <= ss_p0;
      ss_p2 <= ss_p1;
    end
  end

  assign go   = ss_p1 & ~ss_p2;
  assign tick = (state_q == RUNNING) && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    dec_sec = sec_q;
    dec_cs  = cs_q;
    if (cs_q != 7'd0) begin
      dec_cs = cs_q - 7'd1;
    end else if (sec_q != 7'd0) begin
      dec_sec = sec_q - 7'd1;
      dec_cs  = 7'd99;
    end
  end

  assign dec_zero = (dec_sec == 7'd0) && (dec_cs == 7'd0);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load overrides everything; a final tick beats a coincident pause request
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (go && ((sec_q != 7'd0) || (cs_q != 7'd0))) state_d = RUNNING;
        end
        RUNNING: begin
          if (tick && dec_zero) state_d = EXPIRED;
          else if (go)          state_d = PAUSED;
        end
        PAUSED: begin
          if (go) state_d = RUNNING;
        end
        EXPIRED: begin
          if (go) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.running = 1'b0;
    bus.expired = 1'b0;
    case (state_q)
      RUNNING: bus.running = 1'b1;
      EXPIRED: bus.expired = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sec_q   <= 7'd0;
      cs_q    <= 7'd0;
      presc_q <= '0;
    end else if (bus.load) begin
      sec_q   <= sat_sec(bus.load_sec);
      cs_q    <= 7'd0;
      presc_q <= '0;
    end else begin
      if ((state_q == IDLE) && (state_d == RUNNING)) begin
        presc_q <= '0;
      end else if (state_q == RUNNING) begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
      end
      if (tick) begin
        sec_q <= dec_sec;
        cs_q  <= dec_cs;
      end
    end
  end

  // Stage p0: registered digit decode
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hex3_p0 <= 7'b1000000;
      hex2_p0 <= 7'b1000000;
      hex1_p0 <= 7'b1000000;
      hex0_p0 <= 7'b1000000;
    end else begin
      hex3_p0 <= seg_enc(tens_of(sec_q));
      hex2_p0 <= seg_enc(ones_of(sec_q));
      hex1_p0 <= seg_enc(tens_of(cs_q));
      hex0_p0 <= seg_enc(ones_of(cs_q));
    end
  end

  assign bus.HEX3 = hex3_p0;
  assign bus.HEX2 = hex2_p0;
  assign bus.HEX1 = hex1_p0;
  assign bus.HEX0 = hex0_p0;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// load/press/reset traffic, all compared against a remaining-time model.
module tb_countdown_timer;

  localparam int TD = 4;
  localparam int MS = 99;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP  = 3;

  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic clk = 1'b0;
  logic reset = 1'b0;

  countdown_timer_if bus();

  countdown_timer #(.TICK_DIV(TD), .MAX_SEC(MS)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining time as a single centisecond count
  int         m_rem = 0;
  int         m_mode = M_IDLE;
  int         m_phase = 0;
  int         m_disp = 0;
  logic [2:0] m_sh = 3'b000;
  int         n_rem;
  int         n_mode;
  int         n_phase;
  int         ls;
  logic       m_go;
  logic       m_tick;

  always_comb begin
    n_rem   = m_rem;
    n_mode  = m_mode;
    n_phase = m_phase;
    ls      = int'(bus.load_sec);
    m_go    = m_sh[1] & ~m_sh[2];
    m_tick  = 1'b0;
    if (bus.load) begin
      n_rem   = ((ls > MS) ? MS : ls) * 100;
      n_mode  = M_IDLE;
      n_phase = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (m_go && m_rem > 0) begin
            n_mode  = M_RUN;
            n_phase = 0;
          end
        end
        M_RUN: begin
          m_tick  = (m_phase == TD - 1);
          n_phase = m_tick ? 0 : m_phase + 1;
          if (m_tick) n_rem = m_rem - 1;
          if (m_tick && n_rem == 0) n_mode = M_EXP;
          else if (m_go)            n_mode = M_PAUSE;
        end
        M_PAUSE: if (m_go) n_mode = M_RUN;
        default: if (m_go) n_mode = M_IDLE;
      endcase
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem   <= 0;
      m_mode  <= M_IDLE;
      m_phase <= 0;
      m_disp  <= 0;
      m_sh    <= 3'b000;
    end else begin
      m_rem   <= n_rem;
      m_mode  <= n_mode;
      m_phase <= n_phase;
      m_disp  <= m_rem;
      m_sh    <= {m_sh[1:0], bus.start_stop};
    end
  end

  always @(negedge clk) begin
    check("m_hex3", int'(bus.HEX3), int'(SEG[(m_disp / 100) / 10]));
    check("m_hex2", int'(bus.HEX2), int'(SEG[(m_disp / 100) % 10]));
    check("m_hex1", int'(bus.HEX1), int'(SEG[(m_disp % 100) / 10]));
    check("m_hex0", int'(bus.HEX0), int'(SEG[(m_disp % 100) % 10]));
    check("m_running", int'(bus.running), int'(m_mode == M_RUN));
    check("m_expired", int'(bus.expired), int'(m_mode == M_EXP));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    bus.load_sec = 7'(v);
    bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    cyc(1);
  endtask

  task automatic check_disp(input string tag, input int s, input int c);
    check({tag, "_h3"}, int'(bus.HEX3), int'(SEG[s / 10]));
    check({tag, "_h2"}, int'(bus.HEX2), int'(SEG[s % 10]));
    check({tag, "_h1"}, int'(bus.HEX1), int'(SEG[c / 10]));
    check({tag, "_h0"}, int'(bus.HEX0), int'(SEG[c % 10]));
  endtask

  // Start a countdown; returns at the negedge right after go takes effect
  task automatic run_from_load(input int v);
    do_load(v);
    bus.start_stop = 1'b1;
    cyc(3);
    bus.start_stop = 1'b0;
  endtask

  initial begin
    int r;
    bus.load = 1'b0;
    bus.start_stop = 1'b0;
    bus.load_sec = 7'd0;
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    check("rst_hex3", int'(bus.HEX3), 7'b1000000);
    check("rst_hex2", int'(bus.HEX2), 7'b1000000);
    check("rst_hex1", int'(bus.HEX1), 7'b1000000);
    check("rst_hex0", int'(bus.HEX0), 7'b1000000);
    check("rst_running", int'(bus.running), 0);
    check("rst_expired", int'(bus.expired), 0);

    bus.start_stop = 1'b1;
    cyc(5);
    check("idle_zero_go", int'(bus.running), 0);
    bus.start_stop = 1'b0;
    cyc(2);

    do_load(42);
    check("load42_h3", int'(bus.HEX3), 7'b0011001);
    check("load42_h2", int'(bus.HEX2), 7'b0100100);
    check("load42_h1", int'(bus.HEX1), 7'b1000000);
    check("load42_h0", int'(bus.HEX0), 7'b1000000);
    do_load(120);
    check_disp("clamp", 99, 0);

    // Full countdown from 01.00 with borrow
    do_load(1);
    bus.start_stop = 1'b1;
    cyc(2);
    check("go_lat2", int'(bus.running), 0);
    cyc(1);
    check("go_lat3", int'(bus.running), 1);
    bus.start_stop = 1'b0;
    cyc(5);
    check_disp("borrow", 0, 99);
    cyc(394);
    check("pre_exp_run", int'(bus.running), 1);
    check("pre_exp_exp", int'(bus.expired), 0);
    cyc(1);
    check("exp_flag", int'(bus.expired), 1);
    check("exp_run", int'(bus.running), 0);
    cyc(1);
    check_disp("exp_disp", 0, 0);
    bus.start_stop = 1'b1;
    cyc(3);
    check("exp_clear", int'(bus.expired), 0);
    bus.start_stop = 1'b0;
    cyc(2);

    // Pause after ten ticks, resume from held prescaler
    run_from_load(2);
    cyc(39);
    bus.start_stop = 1'b1;
    cyc(3);
    check("paused", int'(bus.running), 0);
    bus.start_stop = 1'b0;
    cyc(50);
    check_disp("frozen", 1, 90);
    bus.start_stop = 1'b1;
    cyc(3);
    check("resumed", int'(bus.running), 1);
    bus.start_stop = 1'b0;
    cyc(4);
    check_disp("resume_tick", 1, 89);

    // Load and go together while running
    run_from_load(5);
    cyc(10);
    bus.start_stop = 1'b1;
    cyc(2);
    bus.load_sec = 7'd7;
    bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    bus.start_stop = 1'b0;
    cyc(1);
    check("ldgo_run", int'(bus.running), 0);
    check_disp("ldgo", 7, 0);
    cyc(10);
    check("ldgo_stay", int'(bus.running), 0);

    // Go coincident with the final tick
    run_from_load(1);
    cyc(397);
    bus.start_stop = 1'b1;
    cyc(3);
    check("gofin_exp", int'(bus.expired), 1);
    check("gofin_run", int'(bus.running), 0);
    bus.start_stop = 1'b0;
    cyc(2);
    bus.start_stop = 1'b1;
    cyc(3);
    bus.start_stop = 1'b0;
    cyc(2);

    // Async reset mid-run at 00.37
    run_from_load(1);
    cyc(253);
    check_disp("at37", 0, 37);
    #2 reset = 1'b0;
    #1;
    check("arst_hex3", int'(bus.HEX3), 7'b1000000);
    check("arst_hex2", int'(bus.HEX2), 7'b1000000);
    check("arst_hex1", int'(bus.HEX1), 7'b1000000);
    check("arst_hex0", int'(bus.HEX0), 7'b1000000);
    check("arst_run", int'(bus.running), 0);
    cyc(1);
    reset = 1'b1;
    cyc(20);
    check("arst_norun", int'(bus.running), 0);
    check_disp("arst_after", 0, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 199));
      bus.load = 1'b0;
      if (r < 4) begin
        bus.load = 1'b1;
        bus.load_sec = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                   : 7'($urandom_range(0, 2));
      end else if (r < 10) begin
        bus.start_stop = ~bus.start_stop;
      end else if (r == 199) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
      cyc(1);
    end
    bus.load = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Count-down counterpart to the team's stopwatch counter on the DE2 board.
- Loads a seconds value from switches and counts down in centisecond resolution from SS.00 to 00.00.
- Raises an expiry flag at 00.00.
- Drives four seven-segment digits (SS.cc) directly; sits at the board top level next to the stopwatch.

Parameters:
- TICK_DIV, 500000, CLOCK_50 cycles per centisecond tick (10 ms at 50 MHz); benches use small values.
- MAX_SEC, 99, ceiling applied to the loaded seconds value.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  active-high, synchronous, level-sampled; loads load_sec.
- start_stop  input  1  asynchronous push-button level, active-high; each rising edge toggles run/pause.
- load_sec  input  7  binary seconds value, 0..127.
- HEX3  output  7  seconds tens digit, active-low segments {g,f,e,d,c,b,a}.
- HEX2  output  7  seconds ones digit.
- HEX1  output  7  centiseconds tens digit.
- HEX0  output  7  centiseconds ones digit.
- running  output  1  high in RUNNING.
- expired  output  1  high in EXPIRED.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; sec=0, cs=0; prescaler=0; sync flops=0.
  - running=0, expired=0; all HEX show "0" (1000000).
- start_stop input path:
  - 2-flop synchronizer, then a rising-edge detector.
  - The detected pulse (go) is 1 cycle wide and occurs 2 cycles after the input rises.
  - State acts on go at the next clock edge.
- Internal registers:
  - sec: 7-bit, 0..99.
  - cs: 7-bit, 0..99.
  - prescaler: 0..TICK_DIV-1.
  - tick: 1-cycle pulse when prescaler wraps; prescaler advances only in RUNNING.
- States and transitions:
  - IDLE: on go, if sec|cs nonzero -> RUNNING with prescaler=0; else stay IDLE.
  - RUNNING: on go -> PAUSED, prescaler held. On tick:
    - cs>0: cs-1.
    - else sec>0: sec-1, cs=99.
    - A decrement that produces sec=0, cs=0 -> EXPIRED in the same edge.
  - PAUSED: on go -> RUNNING; prescaler resumes from its held value. No ticks are counted.
  - EXPIRED: counters stay 00.00; expired=1. go -> IDLE, clears expired, counters stay 0.
- load:
  - Highest synchronous priority, in any state.
  - sec=min(load_sec, MAX_SEC), cs=0, prescaler=0, state=IDLE, expired=0.
  - A go in the same cycle as load is discarded.
- Simultaneous go and tick in RUNNING:
  - The tick's decrement is applied and state -> PAUSED.
  - If that decrement reaches 00.00, EXPIRED wins.
- Display:
  - HEX3=enc(sec/10), HEX2=enc(sec%10), HEX1=enc(cs/10), HEX0=enc(cs%10).
  - HEX outputs are registered, so they lag the counters by 1 cycle.
  - enc, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Timing: full countdown from N.00 takes exactly N*100*TICK_DIV cycles of RUNNING.
- Reset mid-count: async reset returns everything to reset values immediately, regardless of state.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release -> HEX3..0 all 1000000, running=0, expired=0; a go with 00.00 leaves state IDLE.
- Load and clamp:
  - load=1 with load_sec=42 -> HEX3=0011001, HEX2=0100100, HEX1=HEX0=1000000.
  - load_sec=120 -> display 99.00.
- Countdown and borrow (TICK_DIV=4, load 1):
  - Press start_stop -> running=1 three cycles after the press.
  - After 4 cycles -> 00.99.
  - After 100 ticks (400 cycles) -> 00.00, expired=1, running=0.
- Pause/resume (TICK_DIV=4, load 2): run 10 ticks (01.90), press -> counters frozen for 50 cycles; press again -> next tick after the remaining prescaler count gives 01.89.
- Priority: load and go in the same cycle while RUNNING -> state IDLE with the loaded value, no run; go coincident with the final tick -> EXPIRED, not PAUSED.
- Async reset mid-run at 00.37 -> outputs go to reset values before the next CLOCK_50 edge; count does not resume after release.
